// File: rtl/systolic_mm_ctrl_if.sv
// Host and array-edge signal bundle for the 3x3 systolic MAC sequencing controller.
// master = host/array side, slave = controller.
interface systolic_mm_ctrl_if #(
  parameter int DW = 8
);
  logic            wr_en;
  logic            wr_sel;
  logic [3:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            res_valid;
  logic            mac_clr;
  logic            mac_en;
  logic [3*DW-1:0] a_feed;
  logic [3*DW-1:0] b_feed;
  logic [9*DW-1:0] res_in;
  logic [3:0]      rd_addr;
  logic [DW-1:0]   rd_data;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, res_in, rd_addr,
    input  busy, done, res_valid, mac_clr, mac_en, a_feed, b_feed, rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, res_in, rd_addr,
    output busy, done, res_valid, mac_clr, mac_en, a_feed, b_feed, rd_data
  );
endinterface

// File: rtl/systolic_mm_ctrl.sv
// Sequencing controller for the 3x3 output-stationary systolic MAC array: operand
// storage, skewed edge feeds, fixed drain interval and result capture/readback.
module systolic_mm_ctrl #(
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input logic               CLK,
  input logic               RST,
  systolic_mm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [7:0] FEED_LAST  = 8'd4;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t          state_r, state_s;
  logic [7:0]      step_r, step_s;

  logic [DW-1:0]   a_r    [0:8];
  logic [DW-1:0]   b_r    [0:8];
  logic [DW-1:0]   bank_r [0:8];

  logic            busy_r, done_r, valid_r, clr_r, en_r;
  logic            busy_s, done_s, valid_s, clr_s, en_s;
  logic [3*DW-1:0] a_feed_r, b_feed_r, a_feed_s, b_feed_s;
  logic [DW-1:0]   rd_data_r;
  logic [3:0]      off_s;
  logic            wr_ok_s;

  // State and step counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      step_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    case (state_r)
      S_IDLE: begin
        step_s = 8'd0;
        if (bus.start) begin
          state_s = S_CLEAR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_s = S_FEED;
        step_s  = 8'd0;
      end
      S_FEED: begin
        if (step_r == FEED_LAST) begin
          state_s = S_DRAIN;
          step_s  = 8'd0;
        end else begin
          step_s  = step_r + 8'd1;
        end
      end
      S_DRAIN: begin
        if (step_r == DRAIN_LAST) begin
          state_s = S_CAPTURE;
          step_s  = 8'd0;
        end else begin
          step_s  = step_r + 8'd1;
        end
      end
      S_CAPTURE: begin
        state_s = S_IDLE;
        step_s  = 8'd0;
      end
      default: begin
        state_s = S_IDLE;
        step_s  = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs match the occupied state
  always_comb begin
    busy_s   = (state_s != S_IDLE);
    done_s   = (state_s == S_CAPTURE);
    clr_s    = (state_s == S_CLEAR);
    en_s     = (state_s == S_FEED) || (state_s == S_DRAIN);
    a_feed_s = {(3*DW){1'b0}};
    b_feed_s = {(3*DW){1'b0}};
    off_s    = 4'd0;
    if (state_s == S_CAPTURE) begin
      valid_s = 1'b1;
    end else if (state_s == S_CLEAR) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
    // Lane k carries element offset (t - k) of row k of A / column k of B
    for (int k = 0; k < 3; k++) begin
      off_s = step_s[3:0] - 4'(k);
      if ((state_s == S_FEED) && (step_s[3:0] >= 4'(k)) && (off_s <= 4'd2)) begin
        a_feed_s[DW*k +: DW] = a_r[4'(3*k) + off_s];
        b_feed_s[DW*k +: DW] = b_r[(off_s * 4'd3) + 4'(k)];
      end else begin
        a_feed_s[DW*k +: DW] = {DW{1'b0}};
        b_feed_s[DW*k +: DW] = {DW{1'b0}};
      end
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
      clr_r    <= 1'b0;
      en_r     <= 1'b0;
      a_feed_r <= {(3*DW){1'b0}};
      b_feed_r <= {(3*DW){1'b0}};
    end else begin
      busy_r   <= busy_s;
      done_r   <= done_s;
      valid_r  <= valid_s;
      clr_r    <= clr_s;
      en_r     <= en_s;
      a_feed_r <= a_feed_s;
      b_feed_r <= b_feed_s;
    end
  end

  assign wr_ok_s = bus.wr_en && (state_r == S_IDLE) && (bus.wr_addr <= 4'd8);

  // Operand storage, result bank capture and registered readback
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 9; k++) begin
        a_r[k]    <= {DW{1'b0}};
        b_r[k]    <= {DW{1'b0}};
        bank_r[k] <= {DW{1'b0}};
      end
      rd_data_r <= {DW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        if (bus.wr_sel) begin
          b_r[bus.wr_addr] <= bus.wr_data;
        end else begin
          a_r[bus.wr_addr] <= bus.wr_data;
        end
      end
      // Bank updates at the end of CAPTURE, so a read issued in CAPTURE still sees the old run
      if (state_r == S_CAPTURE) begin
        for (int k = 0; k < 9; k++) begin
          bank_r[k] <= bus.res_in[DW*k +: DW];
        end
      end
      if (bus.rd_addr <= 4'd8) begin
        rd_data_r <= bank_r[bus.rd_addr];
      end else begin
        rd_data_r <= {DW{1'b0}};
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.res_valid = valid_r;
  assign bus.mac_clr   = clr_r;
  assign bus.mac_en    = en_r;
  assign bus.a_feed    = a_feed_r;
  assign bus.b_feed    = b_feed_r;
  assign bus.rd_data   = rd_data_r;

endmodule
